// File: rtl/magnetron_power_ctrl_pkg.sv
// Shared definitions for the magnetron power controller: state encoding
// and the derived power-level width.
package magnetron_power_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_COOK   = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } mag_state_e;

    function automatic int lvl_width(input int levels);
        return $clog2(levels + 1);
    endfunction

endpackage

// File: rtl/magnetron_power_ctrl_if.sv
// Front-panel / door / timer bundle feeding the controller, plus the
// magnetron drive and status outputs coming back.
interface magnetron_power_ctrl_if
    import magnetron_power_ctrl_pkg::*;
#(
    parameter int LVL_W = 4
);
    logic               startn;
    logic               stopn;
    logic               clearn;
    logic               door_closed;
    logic               timer_done;
    logic [LVL_W-1:0]   power_level;
    logic               mag_on;
    logic               cooking;
    logic               done;
    logic [STATE_W-1:0] state;

    modport master (
        output startn, stopn, clearn, door_closed, timer_done, power_level,
        input  mag_on, cooking, done, state
    );

    modport slave (
        input  startn, stopn, clearn, door_closed, timer_done, power_level,
        output mag_on, cooking, done, state
    );

endinterface

// File: rtl/magnetron_power_ctrl_duty_slot_counter.sv
// Duty-period position counter: cycles within a slot, slots within a period.
// Holds when disabled, zeroes on clr.
module duty_slot_counter #(
    parameter  int POWER_LEVELS = 10,
    parameter  int SLOT_CYCLES  = 4,
    localparam int SLOT_W = (POWER_LEVELS > 1) ? $clog2(POWER_LEVELS) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic              clr,
    output logic [SLOT_W-1:0] slot_cnt,
    output logic              period_wrap
);
    localparam int CYC_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              cyc_wrap, slot_wrap;

    assign cyc_wrap  = (cyc_q == CYC_W'(SLOT_CYCLES - 1));
    assign slot_wrap = (slot_q == SLOT_W'(POWER_LEVELS - 1));

    always_comb begin
        cyc_d  = cyc_q;
        slot_d = slot_q;
        if (clr) begin
            cyc_d  = '0;
            slot_d = '0;
        end else if (en) begin
            cyc_d = cyc_wrap ? '0 : cyc_q + 1'b1;
            if (cyc_wrap) begin
                slot_d = slot_wrap ? '0 : slot_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc_q  <= '0;
            slot_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            slot_q <= slot_d;
        end
    end

    assign slot_cnt    = slot_q;
    assign period_wrap = en && !clr && cyc_wrap && slot_wrap;

endmodule

// File: rtl/magnetron_power_ctrl.sv
// Clocked cook FSM with slot-based duty cycling of the magnetron drive.
// All outputs are decoded from registers only.
module magnetron_power_ctrl
    import magnetron_power_ctrl_pkg::*;
#(
    parameter int POWER_LEVELS = 10,
    parameter int SLOT_CYCLES  = 4,
    parameter int LVL_W        = lvl_width(POWER_LEVELS)
) (
    input  logic                   clk,
    input  logic                   resetn,
    magnetron_power_ctrl_if.slave  bus
);
    localparam int SLOT_W = (POWER_LEVELS > 1) ? $clog2(POWER_LEVELS) : 1;

    mag_state_e        state_q, state_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic [LVL_W-1:0]  lvl_clamped;
    logic [SLOT_W-1:0] slot_cnt;
    logic              start_ok;
    logic              cnt_en, cnt_clr;
    logic              period_wrap_unused;

    assign lvl_clamped = (bus.power_level > LVL_W'(POWER_LEVELS)) ?
                         LVL_W'(POWER_LEVELS) : bus.power_level;

    assign start_ok = !bus.startn && bus.stopn && bus.door_closed &&
                      !bus.timer_done && (bus.power_level != '0);

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clearn && start_ok) begin
                    state_d = ST_COOK;
                    lvl_d   = lvl_clamped;
                end
            end
            ST_COOK: begin
                if (!bus.clearn) begin
                    state_d = ST_IDLE;
                end else if (bus.timer_done) begin
                    state_d = ST_DONE;
                end else if (!bus.stopn || !bus.door_closed) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (!bus.clearn) begin
                    state_d = ST_IDLE;
                end else if (bus.timer_done) begin
                    state_d = ST_DONE;
                end else if (start_ok) begin
                    state_d = ST_COOK;
                    lvl_d   = lvl_clamped;
                end
            end
            ST_DONE: begin
                if (!bus.clearn || !bus.door_closed) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            lvl_q   <= '0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
        end
    end

    // Counters move only on edges that keep us in COOK, so a pause freezes
    // the exact period position and a resume continues from it.
    assign cnt_en  = (state_q == ST_COOK) && (state_d == ST_COOK);
    assign cnt_clr = (state_d == ST_IDLE);

    duty_slot_counter #(
        .POWER_LEVELS (POWER_LEVELS),
        .SLOT_CYCLES  (SLOT_CYCLES)
    ) u_duty (
        .clk         (clk),
        .resetn      (resetn),
        .en          (cnt_en),
        .clr         (cnt_clr),
        .slot_cnt    (slot_cnt),
        .period_wrap (period_wrap_unused)
    );

    assign bus.mag_on  = (state_q == ST_COOK) && (LVL_W'(slot_cnt) < lvl_q);
    assign bus.cooking = (state_q == ST_COOK);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.state   = state_q;

endmodule
